// File: rtl/sb_pkg.sv
// sb_pkg: shared sideband TX types and constants.
package sb_pkg;
    localparam int SB_WORD_W = 64;
    localparam logic [SB_WORD_W-1:0] SB_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam int SB_REQ_LTSM = 0;
    localparam int SB_REQ_RDI = 1;
    localparam int SB_REQ_ADAPTER = 2;
    typedef enum logic [2:0] {SB_IDLE, SB_PAT, SB_HDR, SB_DATA, SB_GAP} sb_tx_state_e;
endpackage

// File: rtl/sb_rr_arbiter.sv
// sb_rr_arbiter: combinational round-robin pick with a registered pointer.
module sb_rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [IW-1:0]      adv_idx,
    output logic [IW-1:0]      pick,
    output logic               any
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    // Scan from the farthest offset down so the requester nearest the pointer wins.
    always_comb begin
        pick = '0;
        any = 1'b0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                pick = idx;
                any = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (advance) ptr <= (adv_idx == IW'(NUM_REQ - 1)) ? '0 : adv_idx + 1'b1;
endmodule

// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter: schedules sideband packets and SBINIT pattern bursts onto the shared TX serializer.
module sb_tx_arbiter
    import sb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int GAP_CYCLES = 4,
    parameter int PAT_ITER = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_enable,
    input  logic                           i_pat_req,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*SB_WORD_W-1:0]   i_req_hdr,
    input  logic [NUM_REQ-1:0]             i_req_has_data,
    input  logic [NUM_REQ*SB_WORD_W-1:0]   i_req_data,
    input  logic                           i_ser_done,
    output logic                           o_ser_valid,
    output logic [SB_WORD_W-1:0]           o_ser_data,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [NUM_REQ-1:0]             o_req_ack,
    output logic                           o_pat_done,
    output logic                           o_busy
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam sb_tx_state_e POST = (GAP_CYCLES == 0) ? SB_IDLE : SB_GAP;
    sb_tx_state_e state;
    logic [IW-1:0] cur;
    logic [IW-1:0] pick;
    logic any;
    logic has_data;
    logic done_ok;
    logic ack;
    logic [3:0] pat_cnt;
    logic [3:0] gap_cnt;
    // A done coinciding with the load strobe belongs to the previous word and is dropped.
    assign done_ok = i_ser_done && !o_ser_valid;
    assign ack = done_ok && ((state == SB_HDR && !has_data) || state == SB_DATA);
    assign o_busy = state != SB_IDLE;
    sb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk(i_clk),
        .rst_n(i_rst_n),
        .req(i_req_valid),
        .advance(ack),
        .adv_idx(cur),
        .pick(pick),
        .any(any)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= SB_IDLE;
            cur <= '0;
            has_data <= 1'b0;
            pat_cnt <= '0;
            gap_cnt <= '0;
            o_ser_valid <= 1'b0;
            o_ser_data <= '0;
            o_grant <= '0;
            o_req_ack <= '0;
            o_pat_done <= 1'b0;
        end else begin
            o_ser_valid <= 1'b0;
            o_ser_data <= '0;
            o_req_ack <= '0;
            o_pat_done <= 1'b0;
            case (state)
                SB_IDLE:
                    if (i_pat_req) begin
                        state <= SB_PAT;
                        pat_cnt <= '0;
                        o_ser_valid <= 1'b1;
                        o_ser_data <= SB_PATTERN;
                    end else if (i_enable && any) begin
                        state <= SB_HDR;
                        cur <= pick;
                        has_data <= i_req_has_data[pick];
                        o_grant <= NUM_REQ'(1) << pick;
                        o_ser_valid <= 1'b1;
                        o_ser_data <= i_req_hdr[int'(pick)*SB_WORD_W +: SB_WORD_W];
                    end
                SB_PAT:
                    if (done_ok) begin
                        pat_cnt <= (pat_cnt == 4'hF) ? pat_cnt : pat_cnt + 4'd1;
                        if (pat_cnt == 4'(PAT_ITER - 1)) begin
                            o_pat_done <= 1'b1;
                            state <= POST;
                            gap_cnt <= '0;
                        end else begin
                            o_ser_valid <= 1'b1;
                            o_ser_data <= SB_PATTERN;
                        end
                    end
                SB_HDR, SB_DATA:
                    if (ack) begin
                        o_req_ack <= o_grant;
                        o_grant <= '0;
                        state <= POST;
                        gap_cnt <= '0;
                    end else if (done_ok) begin
                        state <= SB_DATA;
                        o_ser_valid <= 1'b1;
                        o_ser_data <= i_req_data[int'(cur)*SB_WORD_W +: SB_WORD_W];
                    end
                SB_GAP: begin
                    gap_cnt <= (gap_cnt == 4'hF) ? gap_cnt : gap_cnt + 4'd1;
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= SB_IDLE;
                end
                default: state <= SB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sb_tx_arbiter.sv
// tb_sb_tx_arbiter: scoreboard bench for sb_tx_arbiter with directed packet and pattern traffic.
module tb_sb_tx_arbiter;
    import sb_pkg::*;
    localparam int SER_LAT = 8;
    localparam logic [63:0] HDR0 = 64'h4000_0000_0025_4000;
    localparam logic [63:0] HDR1 = 64'h4100_0000_0000_0011;
    localparam logic [63:0] HDR2 = 64'h4200_0000_0000_0022;
    localparam logic [63:0] DAT0 = 64'h0BAD_F00D_0000_0000;
    localparam logic [63:0] DAT1 = 64'hDEAD_BEEF_0123_4567;
    localparam int EV_LOAD = 0;
    localparam int EV_ACK = 1;
    localparam int EV_PAT = 2;

    logic clk = 1'b0;
    logic i_rst_n, i_enable, i_pat_req, i_ser_done;
    logic [2:0] i_req_valid, i_req_has_data;
    logic [191:0] i_req_hdr, i_req_data;
    logic o_ser_valid, o_pat_done, o_busy;
    logic [63:0] o_ser_data;
    logic [2:0] o_grant, o_req_ack;

    typedef struct {
        string name;
        int kind;
        logic [63:0] val;
        logic [2:0] grant;
        int lat;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = 0;
    int ser_cnt = 0;

    sb_tx_arbiter #(.NUM_REQ(3), .GAP_CYCLES(4), .PAT_ITER(4)) dut (
        .i_clk(clk),
        .i_rst_n(i_rst_n),
        .i_enable(i_enable),
        .i_pat_req(i_pat_req),
        .i_req_valid(i_req_valid),
        .i_req_hdr(i_req_hdr),
        .i_req_has_data(i_req_has_data),
        .i_req_data(i_req_data),
        .i_ser_done(i_ser_done),
        .o_ser_valid(o_ser_valid),
        .o_ser_data(o_ser_data),
        .o_grant(o_grant),
        .o_req_ack(o_req_ack),
        .o_pat_done(o_pat_done),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Serializer model: raises done for one cycle SER_LAT cycles after each load.
    initial begin
        i_ser_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_ser_done = 1'b0;
            if (!i_rst_n) ser_cnt = 0;
            else if (o_ser_valid) ser_cnt = SER_LAT;
            else if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) i_ser_done = 1'b1;
            end
        end
    end

    task automatic check_ev(int kind, logic [63:0] val);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d val=%h grant=%b, required no event", kind, val, o_grant);
            return;
        end
        e = q.pop_front();
        if (e.kind != kind || e.val !== val || e.grant !== o_grant || (e.lat >= 0 && cyc - last_done != e.lat)) begin
            errors++;
            $display("FAIL %s: got kind=%0d val=%h grant=%b lat=%0d, required kind=%0d val=%h grant=%b lat=%0d",
                     e.name, kind, val, o_grant, cyc - last_done, e.kind, e.val, e.grant, e.lat);
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (o_ser_valid) check_ev(EV_LOAD, o_ser_data);
        if (|o_req_ack) check_ev(EV_ACK, 64'(o_req_ack));
        if (o_pat_done) check_ev(EV_PAT, 64'd0);
        if (i_ser_done) last_done = cyc;
    end

    task automatic push(string name, int kind, logic [63:0] val, logic [2:0] grant, int lat);
        q.push_back('{name, kind, val, grant, lat});
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic chk_zero(string name);
        chk({name, "_valid"}, 64'(o_ser_valid), 64'd0);
        chk({name, "_data"}, o_ser_data, 64'd0);
        chk({name, "_grant"}, 64'(o_grant), 64'd0);
        chk({name, "_ack"}, 64'(o_req_ack), 64'd0);
        chk({name, "_patdone"}, 64'(o_pat_done), 64'd0);
        chk({name, "_busy"}, 64'(o_busy), 64'd0);
    endtask

    task automatic serve(int k, string name, bit rereq);
        int n = 0;
        while (!o_req_ack[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ack_seen"}, 64'(o_req_ack[k]), 64'd1);
        i_req_valid[k] = rereq;
        i_req_has_data[k] = 1'b0;
    endtask

    // Counts busy cycles from the current (ack/pat_done) cycle back to IDLE.
    task automatic gap_len(string name);
        int n = 0;
        while (o_busy && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk(name, 64'(n), 64'd4);
    endtask

    task automatic wait_pat(string name);
        int n = 0;
        while (!o_pat_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(o_pat_done), 64'd1);
    endtask

    task automatic do_reset(string name);
        i_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(name);
        i_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_pattern(string name);
        push({name, "_w0"}, EV_LOAD, SB_PATTERN, 3'b000, -1);
        for (int i = 1; i < 4; i++) push({name, "_w"}, EV_LOAD, SB_PATTERN, 3'b000, 1);
        push({name, "_done"}, EV_PAT, 64'd0, 3'b000, 1);
    endtask

    initial begin
        int n;
        i_rst_n = 1'b0;
        i_enable = 1'b0;
        i_pat_req = 1'b0;
        i_req_valid = '0;
        i_req_has_data = '0;
        i_req_hdr = '0;
        i_req_data = '0;
        // 1. reset
        repeat (3) @(negedge clk);
        chk_zero("reset");
        i_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", 64'(o_busy), 64'd0);
        chk("idle_valid", 64'(o_ser_valid), 64'd0);
        i_enable = 1'b1;
        i_req_hdr[64*SB_REQ_LTSM +: 64] = HDR0;
        i_req_hdr[64*SB_REQ_RDI +: 64] = HDR1;
        i_req_hdr[64*SB_REQ_ADAPTER +: 64] = HDR2;
        i_req_data[64*SB_REQ_LTSM +: 64] = DAT0;
        i_req_data[64*SB_REQ_RDI +: 64] = DAT1;
        // 2. pattern burst
        push_pattern("pat");
        i_pat_req = 1'b1;
        @(negedge clk);
        i_pat_req = 1'b0;
        wait_pat("pat_done_seen");
        gap_len("pat_gap");
        // 3. LTSM header only
        push("ltsm_hdr", EV_LOAD, HDR0, 3'b001, -1);
        push("ltsm_ack", EV_ACK, 64'd1, 3'b000, 1);
        i_req_valid[SB_REQ_LTSM] = 1'b1;
        @(negedge clk);
        chk("ltsm_latency_valid", 64'(o_ser_valid), 64'd1);
        chk("ltsm_latency_grant", 64'(o_grant), 64'd1);
        serve(SB_REQ_LTSM, "ltsm", 1'b0);
        gap_len("ltsm_gap");
        // 4. RDI header plus data
        push("rdi_hdr", EV_LOAD, HDR1, 3'b010, -1);
        push("rdi_data", EV_LOAD, DAT1, 3'b010, 1);
        push("rdi_ack", EV_ACK, 64'd2, 3'b000, 1);
        i_req_valid[SB_REQ_RDI] = 1'b1;
        i_req_has_data[SB_REQ_RDI] = 1'b1;
        serve(SB_REQ_RDI, "rdi", 1'b0);
        gap_len("rdi_gap");
        // 5. round robin from pointer 0, LTSM re-requesting
        do_reset("reset2");
        push("rr0_hdr", EV_LOAD, HDR0, 3'b001, -1);
        push("rr0_ack", EV_ACK, 64'd1, 3'b000, 1);
        push("rr1_hdr", EV_LOAD, HDR1, 3'b010, -1);
        push("rr1_ack", EV_ACK, 64'd2, 3'b000, 1);
        push("rr2_hdr", EV_LOAD, HDR2, 3'b100, -1);
        push("rr2_ack", EV_ACK, 64'd4, 3'b000, 1);
        push("rr3_hdr", EV_LOAD, HDR0, 3'b001, -1);
        push("rr3_ack", EV_ACK, 64'd1, 3'b000, 1);
        i_req_valid = 3'b111;
        serve(SB_REQ_LTSM, "rr0", 1'b1);
        serve(SB_REQ_RDI, "rr1", 1'b0);
        serve(SB_REQ_ADAPTER, "rr2", 1'b0);
        serve(SB_REQ_LTSM, "rr3", 1'b0);
        gap_len("rr_gap");
        // 6a. enable low blocks grants
        i_enable = 1'b0;
        i_req_valid[SB_REQ_RDI] = 1'b1;
        repeat (12) @(negedge clk);
        chk("disabled_busy", 64'(o_busy), 64'd0);
        chk("disabled_grant", 64'(o_grant), 64'd0);
        push("en_hdr", EV_LOAD, HDR1, 3'b010, -1);
        push("en_ack", EV_ACK, 64'd2, 3'b000, 1);
        i_enable = 1'b1;
        serve(SB_REQ_RDI, "en", 1'b0);
        gap_len("en_gap");
        // 6b. pattern wins over a simultaneous request
        push_pattern("prio_pat");
        push("prio_hdr", EV_LOAD, HDR2, 3'b100, -1);
        push("prio_ack", EV_ACK, 64'd4, 3'b000, 1);
        i_pat_req = 1'b1;
        i_req_valid[SB_REQ_ADAPTER] = 1'b1;
        @(negedge clk);
        i_pat_req = 1'b0;
        serve(SB_REQ_ADAPTER, "prio", 1'b0);
        gap_len("prio_gap");
        // 6c. reset while the data word is shifting
        push("rst_hdr", EV_LOAD, HDR0, 3'b001, -1);
        push("rst_data", EV_LOAD, DAT0, 3'b001, 1);
        i_req_valid[SB_REQ_LTSM] = 1'b1;
        i_req_has_data[SB_REQ_LTSM] = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_data_loaded", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
        i_rst_n = 1'b0;
        i_req_valid = '0;
        i_req_has_data = '0;
        @(negedge clk);
        chk_zero("mid_reset");
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_busy", 64'(o_busy), 64'd0);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
